// File: rtl/knn_loader_pkg.sv
// knn_loader_pkg
// Shared definitions for the KNN loader:
//   - byte offsets of the KNN peripheral register bank (relative to KNN_BASE)
//   - loader state encoding
//   - WSTRB_ALL, the all-lanes write strobe for one 32-bit word
package knn_loader_pkg;

    // KNN register bank byte offsets
    localparam logic [31:0] KNN_RESET     = 32'h0000_0000;
    localparam logic [31:0] KNN_START     = 32'h0000_0004;
    localparam logic [31:0] KNN_TEST_PT   = 32'h0000_0008;
    localparam logic [31:0] KNN_VALID_OUT = 32'h0000_000C;
    localparam logic [31:0] KNN_IN1       = 32'h0000_0010;  // +4 per neighbour index
    localparam logic [31:0] KNN_DATA_PT0  = 32'h0000_0100;  // +4 per data point

    // Write strobe covering every byte lane of one 32-bit word
    localparam logic [3:0] WSTRB_ALL = 4'b1111;

    // Loader sequencing states
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RST_HI  = 4'd1,
        S_RST_LO  = 4'd2,
        S_SRC_RD  = 4'd3,
        S_PT_WR   = 4'd4,
        S_TEST_WR = 4'd5,
        S_GO_HI   = 4'd6,
        S_GO_LO   = 4'd7,
        S_POLL    = 4'd8,
        S_RES_RD  = 4'd9,
        S_DONE    = 4'd10
    } state_e;

endpackage

// File: rtl/knn_loader_if.sv
// knn_loader_if
// Native single-outstanding bus between an initiator and a slave.
//   m_valid  request valid            (master -> slave)
//   m_addr   byte address             (master -> slave)
//   m_wdata  write data               (master -> slave)
//   m_wstrb  byte strobes, 0 = read   (master -> slave)
//   m_rdata  read data                (slave -> master), valid with m_ready
//   m_ready  transaction complete     (slave -> master)
interface knn_loader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  m_valid;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic [DATA_W-1:0]     m_rdata;
    logic                  m_ready;

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_rdata, m_ready
    );

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb,
        output m_rdata, m_ready
    );
endinterface

// File: rtl/knn_nat_master.sv
// knn_nat_master
// Single-transaction native initiator. The request registers are loaded when
// req_i is high and nothing is outstanding, held stable until m_ready, and
// m_valid drops in the cycle after completion, so back-to-back transactions
// take at least two cycles each.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   req_i      transaction wanted (level; sampled only while idle)
//   addr_i     byte address
//   wdata_i    write data
//   we_i       1 = write (all strobes), 0 = read (zero strobes)
//   ack_o      combinational: completes in this cycle (m_valid && m_ready)
//   rdata_o    read data, meaningful while ack_o is high
//   bus        native bus, master side
module knn_nat_master
    import knn_loader_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              we_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    knn_loader_if.master      bus
);

    logic                valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;

    // Issue when idle, hold while waiting for ready, retire on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            wstrb_q <= {(DATA_W/8){1'b0}};
        end else if (valid_q) begin
            // completion frees the slot; the registers keep their last value
            valid_q <= !bus.m_ready;
        end else if (req_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            wstrb_q <= we_i ? {(DATA_W/32){WSTRB_ALL}} : {(DATA_W/8){1'b0}};
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.m_valid = valid_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.m_wstrb = wstrb_q;

    assign ack_o   = valid_q && bus.m_ready;
    assign rdata_o = bus.m_rdata;

endmodule

// File: rtl/knn_loader.sv
// knn_loader
// Hardware initiator that programs the KNN peripheral through its native slave
// port: resets the core, copies N_PTS data points from source memory, writes
// the test point, pulses start, polls valid-out and reads back K neighbour
// indices.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      one-cycle run request, accepted only in IDLE
//   test_pt    test point, captured when start is accepted
//   busy       high from accepted start until DONE
//   done       one-cycle pulse when res_idx is valid
//   res_idx    K neighbour indices, index 1 in the LSBs
//   err        (KNN_LOADER_TIMEOUT_EN only) poll limit reached without valid-out
//   nat        native bus, master side
// Optional build: define KNN_LOADER_TIMEOUT_EN to bound the valid-out poll to
// POLL_MAX reads and add the err output.
module knn_loader
    import knn_loader_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              N_PTS    = 128,
    parameter int              K        = 6,
    parameter int              IDX_W    = 7,
    parameter logic [ADDR_W-1:0] SRC_BASE = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] KNN_BASE = 32'h1000_0000
`ifdef KNN_LOADER_TIMEOUT_EN
    ,
    parameter int              POLL_MAX = 4096
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_W-1:0]    test_pt,
    output logic                 busy,
    output logic                 done,
    output logic [K*IDX_W-1:0]   res_idx,
`ifdef KNN_LOADER_TIMEOUT_EN
    output logic                 err,
`endif
    knn_loader_if.master         nat
);

    localparam int IW = (N_PTS > 1) ? $clog2(N_PTS) : 1;
    localparam int JW = (K > 1) ? $clog2(K) : 1;
`ifdef KNN_LOADER_TIMEOUT_EN
    localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
`endif

    state_e                   state_q;
    logic [IW-1:0]            i_q;
    logic [JW-1:0]            j_q;
    logic [DATA_W-1:0]        buf_q;
    logic [DATA_W-1:0]        test_q;
    logic [K-1:0][IDX_W-1:0]  res_q;
    logic                     busy_q;
    logic                     done_q;
`ifdef KNN_LOADER_TIMEOUT_EN
    logic [PW-1:0]            poll_q;
    logic                     err_q;
`endif

    logic                     nat_req;
    logic [ADDR_W-1:0]        nat_addr;
    logic [DATA_W-1:0]        nat_wdata;
    logic                     nat_we;
    logic                     nat_ack;
    logic [DATA_W-1:0]        nat_rdata;

    // Word offsets of the current point / index, as byte addresses
    logic [ADDR_W-1:0]        i_off;
    logic [ADDR_W-1:0]        j_off;
    assign i_off = {{(ADDR_W-IW-2){1'b0}}, i_q, 2'b00};
    assign j_off = {{(ADDR_W-JW-2){1'b0}}, j_q, 2'b00};

    // Transaction wanted by the current state
    always_comb begin
        nat_req   = 1'b1;
        nat_we    = 1'b1;
        nat_addr  = KNN_BASE;
        nat_wdata = {DATA_W{1'b0}};
        case (state_q)
            S_RST_HI: begin
                nat_addr  = KNN_BASE + ADDR_W'(KNN_RESET);
                nat_wdata = DATA_W'(1);
            end
            S_RST_LO: begin
                nat_addr  = KNN_BASE + ADDR_W'(KNN_RESET);
            end
            S_SRC_RD: begin
                nat_we    = 1'b0;
                nat_addr  = SRC_BASE + i_off;
            end
            S_PT_WR: begin
                nat_addr  = KNN_BASE + ADDR_W'(KNN_DATA_PT0) + i_off;
                nat_wdata = buf_q;
            end
            S_TEST_WR: begin
                nat_addr  = KNN_BASE + ADDR_W'(KNN_TEST_PT);
                nat_wdata = test_q;
            end
            S_GO_HI: begin
                nat_addr  = KNN_BASE + ADDR_W'(KNN_START);
                nat_wdata = DATA_W'(1);
            end
            S_GO_LO: begin
                nat_addr  = KNN_BASE + ADDR_W'(KNN_START);
            end
            S_POLL: begin
                nat_we    = 1'b0;
                nat_addr  = KNN_BASE + ADDR_W'(KNN_VALID_OUT);
            end
            S_RES_RD: begin
                nat_we    = 1'b0;
                nat_addr  = KNN_BASE + ADDR_W'(KNN_IN1) + j_off;
            end
            S_IDLE, S_DONE: begin
                nat_req   = 1'b0;
            end
            default: begin
                nat_req   = 1'b0;
            end
        endcase
    end

    knn_nat_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_nat (
        .clk     (clk),
        .rst     (rst),
        .req_i   (nat_req),
        .addr_i  (nat_addr),
        .wdata_i (nat_wdata),
        .we_i    (nat_we),
        .ack_o   (nat_ack),
        .rdata_o (nat_rdata),
        .bus     (nat)
    );

    // Run sequencer: every bus state advances on the completion of its transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= {IW{1'b0}};
            j_q     <= {JW{1'b0}};
            buf_q   <= {DATA_W{1'b0}};
            test_q  <= {DATA_W{1'b0}};
            res_q   <= {(K*IDX_W){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef KNN_LOADER_TIMEOUT_EN
            poll_q  <= {PW{1'b0}};
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RST_HI;
                        test_q  <= test_pt;
                        busy_q  <= 1'b1;
`ifdef KNN_LOADER_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                S_RST_HI: begin
                    if (nat_ack) state_q <= S_RST_LO;
                end
                S_RST_LO: begin
                    if (nat_ack) begin
                        state_q <= S_SRC_RD;
                        i_q     <= {IW{1'b0}};
                    end
                end
                S_SRC_RD: begin
                    if (nat_ack) begin
                        buf_q   <= nat_rdata;
                        state_q <= S_PT_WR;
                    end
                end
                S_PT_WR: begin
                    if (nat_ack) begin
                        if (i_q == IW'(N_PTS - 1)) begin
                            state_q <= S_TEST_WR;
                        end else begin
                            i_q     <= i_q + IW'(1);
                            state_q <= S_SRC_RD;
                        end
                    end
                end
                S_TEST_WR: begin
                    if (nat_ack) state_q <= S_GO_HI;
                end
                S_GO_HI: begin
                    if (nat_ack) state_q <= S_GO_LO;
                end
                S_GO_LO: begin
                    if (nat_ack) begin
                        state_q <= S_POLL;
`ifdef KNN_LOADER_TIMEOUT_EN
                        poll_q  <= {PW{1'b0}};
`endif
                    end
                end
                S_POLL: begin
                    // staying in POLL makes the master reissue on the idle cycle
                    if (nat_ack) begin
                        if (nat_rdata[0]) begin
                            j_q     <= {JW{1'b0}};
                            state_q <= S_RES_RD;
                        end
`ifdef KNN_LOADER_TIMEOUT_EN
                        else if (poll_q == PW'(POLL_MAX - 1)) begin
                            // give up; results from the previous run stay in place
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            poll_q  <= poll_q + PW'(1);
                        end
`endif
                    end
                end
                S_RES_RD: begin
                    if (nat_ack) begin
                        res_q[j_q] <= nat_rdata[IDX_W-1:0];
                        if (j_q == JW'(K - 1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            j_q     <= j_q + JW'(1);
                        end
                    end
                end
                S_DONE: begin
                    // start is ignored here; IDLE accepts it from the next cycle
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign res_idx = res_q;
`ifdef KNN_LOADER_TIMEOUT_EN
    assign err     = err_q;
`endif

endmodule

// File: tb/tb_knn_loader.sv
// tb_knn_loader
// Scoreboard bench for knn_loader with N_PTS=4, K=6. Expected bus transactions
// and run results are queued when a run is launched; a negedge monitor that
// also models the native slave pops and compares them as the DUT presents them.
module tb_knn_loader;
    import knn_loader_pkg::*;

    localparam logic [31:0] KB = 32'h1000_0000;
    localparam logic [41:0] RES_EXP = {7'd0, 7'd0, 7'd3, 7'd0, 7'd2, 7'd1};

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } txn_t;

    typedef struct {
        logic [41:0] res;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] test_pt;
    logic        busy;
    logic        done;
    logic [41:0] res_idx;
    logic        err_s;

    knn_loader_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef KNN_LOADER_TIMEOUT_EN
    knn_loader #(
        .ADDR_W(32), .DATA_W(32), .N_PTS(4), .K(6), .IDX_W(7),
        .SRC_BASE(32'h0000_0000), .KNN_BASE(32'h1000_0000), .POLL_MAX(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .test_pt(test_pt),
        .busy(busy), .done(done), .res_idx(res_idx), .err(err_s), .nat(bus)
    );
`else
    knn_loader #(
        .ADDR_W(32), .DATA_W(32), .N_PTS(4), .K(6), .IDX_W(7),
        .SRC_BASE(32'h0000_0000), .KNN_BASE(32'h1000_0000)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .test_pt(test_pt),
        .busy(busy), .done(done), .res_idx(res_idx), .nat(bus)
    );
    assign err_s = 1'b0;
`endif

    always #5 clk = ~clk;

    txn_t exp_q[$];
    res_t exp_res_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   valid_rd_cnt = 0;
    int   zero_polls = 0;
    int   max_delay = 0;
    int   wait_cnt = 0;
    logic prev_done = 1'b0;
    logic held_v = 1'b0;
    logic [31:0] held_addr, held_wdata;
    logic [3:0]  held_wstrb;

    logic [31:0] src_vals [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
    // upper bits are junk so that only the low IDX_W bits may be kept
    logic [31:0] in_vals [6] = '{32'hABCD_0001, 32'h0000_0002, 32'h0000_0000,
                                 32'hFF00_0003, 32'h0000_0080, 32'h0000_0000};

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        logic [31:0] off;
        if (a == KB + KNN_VALID_OUT)
            return (valid_rd_cnt >= zero_polls) ? 32'hFFFF_FF01 : 32'hFFFF_FFFE;
        off = a - (KB + KNN_IN1);
        if (off < 32'd24) return in_vals[off[4:2]];
        if (a < 32'd16) return src_vals[a[3:2]];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.addr = a; t.wdata = d; t.we = 1'b1;
        exp_q.push_back(t);
    endtask

    task automatic push_r(input logic [31:0] a);
        txn_t t;
        t.addr = a; t.wdata = 32'd0; t.we = 1'b0;
        exp_q.push_back(t);
    endtask

    // Full expected transaction stream and result for one run
    task automatic push_run(input int polls, input logic [41:0] res, input logic err);
        res_t r;
        push_w(KB + KNN_RESET, 32'd1);
        push_w(KB + KNN_RESET, 32'd0);
        for (int i = 0; i < 4; i++) begin
            push_r(32'h0000_0000 + 32'(4 * i));
            push_w(KB + KNN_DATA_PT0 + 32'(4 * i), src_vals[i]);
        end
        push_w(KB + KNN_TEST_PT, 32'd25);
        push_w(KB + KNN_START, 32'd1);
        push_w(KB + KNN_START, 32'd0);
        for (int p = 0; p < polls; p++) push_r(KB + KNN_VALID_OUT);
        if (!err) begin
            for (int j = 0; j < 6; j++) push_r(KB + KNN_IN1 + 32'(4 * j));
        end
        r.res = res; r.err = err;
        exp_res_q.push_back(r);
    endtask

    // Slave model plus monitor: stability, transaction and result checks
    always @(negedge clk) begin
        if (rst) begin
            bus.m_ready = 1'b0;
            bus.m_rdata = 32'd0;
            held_v = 1'b0;
            wait_cnt = 0;
        end else begin
            if (bus.m_valid && held_v) begin
                n_cmp++;
                if (bus.m_addr !== held_addr || bus.m_wdata !== held_wdata || bus.m_wstrb !== held_wstrb) begin
                    n_bad++;
                    $display("FAIL hold: got %h/%h/%h expected %h/%h/%h", bus.m_addr, bus.m_wdata,
                             bus.m_wstrb, held_addr, held_wdata, held_wstrb);
                end
            end
            if (bus.m_valid && !bus.m_ready) begin
                if (wait_cnt == 0) begin
                    bus.m_ready = 1'b1;
                    bus.m_rdata = slave_read(bus.m_addr);
                    if (bus.m_addr == KB + KNN_VALID_OUT) valid_rd_cnt++;
                    held_v = 1'b0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL txn: got unexpected addr %h wstrb %h", bus.m_addr, bus.m_wstrb);
                    end else begin
                        txn_t e;
                        e = exp_q.pop_front();
                        if (bus.m_addr !== e.addr || bus.m_wstrb !== (e.we ? 4'hF : 4'h0) ||
                            (e.we && bus.m_wdata !== e.wdata)) begin
                            n_bad++;
                            $display("FAIL txn: got addr %h wdata %h wstrb %h expected addr %h wdata %h we %0d",
                                     bus.m_addr, bus.m_wdata, bus.m_wstrb, e.addr, e.wdata, e.we);
                        end
                    end
                end else begin
                    wait_cnt--;
                    held_v = 1'b1;
                    held_addr = bus.m_addr;
                    held_wdata = bus.m_wdata;
                    held_wstrb = bus.m_wstrb;
                end
            end else begin
                bus.m_ready = 1'b0;
                wait_cnt = (max_delay == 0) ? 0 : int'($urandom_range(0, max_delay));
                held_v = 1'b0;
            end
            if (done) begin
                chk("done_width", {63'd0, prev_done}, 64'd0);
                chk("busy_at_done", {63'd0, busy}, 64'd0);
                chk("txn_left_at_done", 64'(exp_q.size()), 64'd0);
                n_cmp++;
                if (exp_res_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL result: got unexpected done, res_idx %h", res_idx);
                end else begin
                    res_t r;
                    r = exp_res_q.pop_front();
                    if (res_idx !== r.res || err_s !== r.err) begin
                        n_bad++;
                        $display("FAIL result: got res_idx %h err %0d expected %h err %0d",
                                 res_idx, err_s, r.res, r.err);
                    end
                end
                done_cnt++;
            end
        end
        prev_done = done;
    end

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1; test_pt = 32'd25;
        @(negedge clk);
        start = 1'b0; test_pt = 32'd99;  // must have been latched already
    endtask

    task automatic wait_done(input string name);
        int c0;
        c0 = done_cnt;
        for (int k = 0; k < 20000 && done_cnt == c0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({name, "_done_pulses"}, 64'(done_cnt - c0), 64'd1);
    endtask

    task automatic run(input string name, input int zp, input int md, input int polls,
                       input logic [41:0] res, input logic err);
        zero_polls = zp; max_delay = md; valid_rd_cnt = 0;
        #1;
        push_run(polls, res, err);
        start_pulse();
        wait_done(name);
        chk({name, "_valid_reads"}, 64'(valid_rd_cnt), 64'(polls));
    endtask

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; test_pt = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_res", {22'd0, res_idx}, 64'd0);
        chk("rst_valid", {63'd0, bus.m_valid}, 64'd0);
        chk("rst_wstrb", {60'd0, bus.m_wstrb}, 64'd0);
        rst = 1'b0;

        run("zero_wait", 0, 0, 1, RES_EXP, 1'b0);
        run("rand_wait", 0, 7, 1, RES_EXP, 1'b0);
        run("poll50", 50, 2, 51, RES_EXP, 1'b0);

        // start during busy, in the done cycle, and the cycle after done
        max_delay = 0; zero_polls = 0; valid_rd_cnt = 0;
        #1;
        push_run(1, RES_EXP, 1'b0);
        start_pulse();
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (done) begin found = 1'b1; break; end
        end
        chk("busy_start_done", {63'd0, found}, 64'd1);
        start = 1'b1; test_pt = 32'd25;
        #1;
        push_run(1, RES_EXP, 1'b0);
        @(negedge clk);
        chk("start_in_done_ignored", {63'd0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0; test_pt = 32'd99;
        chk("start_after_done_taken", {63'd0, busy}, 64'd1);
        wait_done("after_done");

        // reset in the middle of the second point write
        #1;
        push_run(1, RES_EXP, 1'b0);
        start_pulse();
        found = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            if (bus.m_valid && bus.m_addr == KB + KNN_DATA_PT0 + 32'd4) begin found = 1'b1; break; end
        end
        chk("reach_pt1_wr", {63'd0, found}, 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, bus.m_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_res", {22'd0, res_idx}, 64'd0);
        exp_q.delete();
        exp_res_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run("post_rst", 0, 3, 1, RES_EXP, 1'b0);

`ifdef KNN_LOADER_TIMEOUT_EN
        run("timeout", 100000, 0, 8, RES_EXP, 1'b1);
        run("after_timeout", 0, 0, 1, RES_EXP, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
